// File: rtl/riscv_store_tag_unit_pkg.sv
// ----------------------------------------------------------------------------
// riscv_store_tag_unit_pkg
// Shared types and helpers for the store tag-write path.
//   TAG_BE_WIDTH     : byte lanes per tag write (one tag bit per byte)
//   TAG_ADDR_W       : word-address width for the default 32-bit byte address
//   tag_wr_entry_t   : {addr_w, be, wtag}, the pending tag-write record
//   tag_port_state_e : tag-memory port FSM states
//   tag_wdata()      : replicate a scalar tag over the enabled byte lanes
// ----------------------------------------------------------------------------
package riscv_store_tag_unit_pkg;

  localparam int TAG_BE_WIDTH = 4;
  localparam int TAG_ADDR_W   = 30;

  typedef struct packed {
    logic [TAG_ADDR_W-1:0]   addr_w;
    logic [TAG_BE_WIDTH-1:0] be;
    logic [TAG_BE_WIDTH-1:0] wtag;
  } tag_wr_entry_t;

  typedef enum logic {
    TP_IDLE = 1'b0,
    TP_REQ  = 1'b1
  } tag_port_state_e;

  function automatic logic [TAG_BE_WIDTH-1:0] tag_wdata(
    input logic                    t,
    input logic [TAG_BE_WIDTH-1:0] be
  );
    return {TAG_BE_WIDTH{t}} & be;
  endfunction

endpackage

// File: rtl/riscv_tag_fifo.sv
// ----------------------------------------------------------------------------
// riscv_tag_fifo
// Synchronous FIFO with wrap-around read/write pointers and an occupancy
// counter. Simultaneous push and pop are supported; a push while full or a
// pop while empty is ignored. The head entry is presented combinationally.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (control state only)
//   i_push     : write i_wdata at the tail
//   i_pop      : retire the head entry
//   i_wdata    : entry to write
//   o_rdata    : head entry
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module riscv_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(CNT_W-1){1'b0}}, w_do_push}
                         - {{(CNT_W-1){1'b0}}, w_do_pop};
    end
  end

  // Storage carries no reset: an entry is only observed after it is written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/riscv_store_tag_unit.sv
// ----------------------------------------------------------------------------
// riscv_store_tag_unit
// Execute-stage consumer of the store enables from the enable-tag decoder.
// For each accepted store it computes the destination memory tag
//   t = (enable_a & addr_tag) | (enable_b & data_tag)
// and queues {word address, be, {4{t}} & be} in program order. The head entry
// is issued to the tag memory over a req/gnt port; EX is stalled while the
// queue is full. Zero tags are written too, since they clear stale taint.
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   ex_valid_i                  : EX instruction valid and advancing
//   is_store_i                  : instruction is a store
//   enable_a_i, enable_b_i      : address / source tag propagation enables
//   store_addr_i                : effective byte address
//   addr_tag_i, data_tag_i      : rs1 / rs2 tags
//   data_be_i                   : store byte enables
//   ex_stall_o                  : queue full, EX must hold
//   tag_req_o, tag_gnt_i        : tag-memory request / grant
//   tag_addr_o, tag_be_o,
//   tag_wdata_o                 : head write (word aligned, be, tag bits)
//   idle_o                      : queue empty and no request outstanding
//   tcr_check_i, store_exc_o    : tainted-address check enable / exception
//                                 pulse (only with DIFT_STORE_CHECK_EN)
//
// Configuration macro: DIFT_STORE_CHECK_EN. When defined, an accepted store
// whose address operand is tainted while tcr_check_i is set raises a
// one-cycle store_exc_o and is not queued.
// ----------------------------------------------------------------------------
module riscv_store_tag_unit
  import riscv_store_tag_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid_i,
  input  logic                    is_store_i,
  input  logic                    enable_a_i,
  input  logic                    enable_b_i,
  input  logic [ADDR_WIDTH-1:0]   store_addr_i,
  input  logic                    addr_tag_i,
  input  logic                    data_tag_i,
  input  logic [TAG_BE_WIDTH-1:0] data_be_i,
  output logic                    ex_stall_o,
  output logic                    tag_req_o,
  input  logic                    tag_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tag_addr_o,
  output logic [TAG_BE_WIDTH-1:0] tag_be_o,
  output logic [TAG_BE_WIDTH-1:0] tag_wdata_o,
  output logic                    idle_o
`ifdef DIFT_STORE_CHECK_EN
  ,
  input  logic                    tcr_check_i,
  output logic                    store_exc_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Same layout as tag_wr_entry_t, sized for this instance's address width.
  typedef struct packed {
    logic [ADDR_WIDTH-3:0]   addr_w;
    logic [TAG_BE_WIDTH-1:0] be;
    logic [TAG_BE_WIDTH-1:0] wtag;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  logic            w_tag;
  entry_t          w_push_entry;
  entry_t          w_head;
  logic            w_unused_addr_lsb;

  tag_port_state_e r_state;
  logic            r_tag_req;

  assign w_unused_addr_lsb = ^store_addr_i[1:0];

  // Stall comes from the registered occupancy only, so a grant never feeds
  // back combinationally into EX.
  assign ex_stall_o = w_full;
  assign w_accept   = ex_valid_i & is_store_i & ~w_full;
  assign w_pop      = r_tag_req & tag_gnt_i;

  assign w_tag               = (enable_a_i & addr_tag_i) | (enable_b_i & data_tag_i);
  assign w_push_entry.addr_w = store_addr_i[ADDR_WIDTH-1:2];
  assign w_push_entry.be     = data_be_i;
  assign w_push_entry.wtag   = tag_wdata(w_tag, data_be_i);

`ifdef DIFT_STORE_CHECK_EN
  logic w_block;
  logic r_store_exc;

  assign w_block     = addr_tag_i & tcr_check_i;
  assign w_push      = w_accept & ~w_block;
  assign store_exc_o = r_store_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_store_exc <= 1'b0;
    else     r_store_exc <= w_accept & w_block;
  end
`else
  assign w_push = w_accept;
`endif

  riscv_tag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Port FSM. A push always moves to (or keeps) REQ on the next cycle; there
  // is no bypass, so a push into an empty queue requests one cycle later.
  // The request drops only when the last entry is granted with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= TP_IDLE;
      r_tag_req <= 1'b0;
    end else begin
      case (r_state)
        TP_IDLE: begin
          if (w_push) begin
            r_state   <= TP_REQ;
            r_tag_req <= 1'b1;
          end
        end
        TP_REQ: begin
          if (w_pop && (w_count == CNT_W'(1)) && !w_push) begin
            r_state   <= TP_IDLE;
            r_tag_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= TP_IDLE;
          r_tag_req <= 1'b0;
        end
      endcase
    end
  end

  // Head fields are gated by the request so the port reads zero while idle
  // (the storage itself is not reset).
  assign tag_req_o   = r_tag_req;
  assign tag_addr_o  = r_tag_req ? {w_head.addr_w, 2'b00} : '0;
  assign tag_be_o    = r_tag_req ? w_head.be   : '0;
  assign tag_wdata_o = r_tag_req ? w_head.wtag : '0;
  assign idle_o      = (r_state == TP_IDLE) & w_empty;

endmodule

// File: tb/tb_riscv_store_tag_unit.sv
module tb_riscv_store_tag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, is_store_i, enable_a_i, enable_b_i;
  logic [31:0] store_addr_i;
  logic        addr_tag_i, data_tag_i;
  logic [3:0]  data_be_i;
  logic        ex_stall_o, tag_req_o, tag_gnt_i, idle_o;
  logic [31:0] tag_addr_o;
  logic [3:0]  tag_be_o, tag_wdata_o;
`ifdef DIFT_STORE_CHECK_EN
  logic        tcr_check_i;
  logic        store_exc_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  wd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_store_tag_unit #(.FIFO_DEPTH(2), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .is_store_i   (is_store_i),
    .enable_a_i   (enable_a_i),
    .enable_b_i   (enable_b_i),
    .store_addr_i (store_addr_i),
    .addr_tag_i   (addr_tag_i),
    .data_tag_i   (data_tag_i),
    .data_be_i    (data_be_i),
    .ex_stall_o   (ex_stall_o),
    .tag_req_o    (tag_req_o),
    .tag_gnt_i    (tag_gnt_i),
    .tag_addr_o   (tag_addr_o),
    .tag_be_o     (tag_be_o),
    .tag_wdata_o  (tag_wdata_o),
    .idle_o       (idle_o)
`ifdef DIFT_STORE_CHECK_EN
    ,
    .tcr_check_i  (tcr_check_i),
    .store_exc_o  (store_exc_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every granted write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && tag_req_o === 1'b1 && tag_gnt_i === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", tag_addr_o, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr",  tag_addr_o,  e.addr);
        chk("wr_be",    {28'd0, tag_be_o},    {28'd0, e.be});
        chk("wr_wdata", {28'd0, tag_wdata_o}, {28'd0, e.wd});
      end
    end
  end

  // Present one store for one cycle (called at posedge+1, returns at the
  // following posedge+1). acc is the bench's expectation of acceptance.
  task automatic store(input logic [31:0] a, input logic [3:0] be,
                       input logic ea, input logic eb, input logic at,
                       input logic dt, input bit acc);
    exp_t e;
    logic t;
    ex_valid_i = 1'b1; is_store_i = 1'b1;
    enable_a_i = ea; enable_b_i = eb;
    addr_tag_i = at; data_tag_i = dt;
    store_addr_i = a; data_be_i = be;
    chk("stall_at_present", {31'd0, ex_stall_o}, {31'd0, !acc});
    t = (ea & at) | (eb & dt);
    if (acc) begin
      e.addr = {a[31:2], 2'b00};
      e.be   = be;
      e.wd   = {4{t}} & be;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ex_valid_i = 1'b0; is_store_i = 1'b0;
    enable_a_i = 1'b0; enable_b_i = 1'b0;
    addr_tag_i = 1'b0; data_tag_i = 1'b0;
    store_addr_i = '0; data_be_i = '0;
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    ex_valid_i = 1'b0; is_store_i = 1'b0; enable_a_i = 1'b0; enable_b_i = 1'b0;
    store_addr_i = '0; addr_tag_i = 1'b0; data_tag_i = 1'b0; data_be_i = '0;
    tag_gnt_i = 1'b0;
`ifdef DIFT_STORE_CHECK_EN
    tcr_check_i = 1'b0;
`endif
    #1;
    chk("rst_req",   {31'd0, tag_req_o},  32'd0);
    chk("rst_idle",  {31'd0, idle_o},     32'd1);
    chk("rst_stall", {31'd0, ex_stall_o}, 32'd0);
    chk("rst_addr",  tag_addr_o,          32'd0);
    chk("rst_wdata", {28'd0, tag_wdata_o}, 32'd0);
`ifdef DIFT_STORE_CHECK_EN
    chk("rst_exc",   {31'd0, store_exc_o}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single store, grant held high.
    tag_gnt_i = 1'b1;
    store(32'h0000_1006, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("single_req",   {31'd0, tag_req_o}, 32'd1);
    chk("single_addr",  tag_addr_o, 32'h0000_1004);
    chk("single_be",    {28'd0, tag_be_o},    32'hC);
    chk("single_wdata", {28'd0, tag_wdata_o}, 32'hC);
    @(posedge clk); #1;
    chk("single_done_req",  {31'd0, tag_req_o}, 32'd0);
    chk("single_done_idle", {31'd0, idle_o},    32'd1);

    // Non-store cycle has no effect.
    ex_valid_i = 1'b1; is_store_i = 1'b0; data_be_i = 4'hF; addr_tag_i = 1'b1; enable_a_i = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0; data_be_i = '0; addr_tag_i = 1'b0; enable_a_i = 1'b0;
    chk("nonstore_req",  {31'd0, tag_req_o}, 32'd0);
    chk("nonstore_idle", {31'd0, idle_o},    32'd1);

    // Zero tag is still written.
    store(32'h0000_2000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("zero_req",   {31'd0, tag_req_o}, 32'd1);
    chk("zero_wdata", {28'd0, tag_wdata_o}, 32'd0);
    @(posedge clk); #1;

    // Back-pressure with depth 2.
    tag_gnt_i = 1'b0;
    store(32'h0000_3000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    store(32'h0000_3104, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_stall_full", {31'd0, ex_stall_o}, 32'd1);
    chk("bp_req_hold",   {31'd0, tag_req_o},  32'd1);
    chk("bp_head_first", tag_addr_o, 32'h0000_3000);
    store(32'h0000_3208, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_still_stall", {31'd0, ex_stall_o}, 32'd1);
    chk("bp_head_stable", tag_addr_o, 32'h0000_3000);
    tag_gnt_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_stall_release", {31'd0, ex_stall_o}, 32'd0);
    chk("bp_head_second",   tag_addr_o, 32'h0000_3104);
    // Re-presented store: push and pop at count 1.
    store(32'h0000_3208, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pp_req",   {31'd0, tag_req_o},  32'd1);
    chk("pp_head",  tag_addr_o,          32'h0000_3208);
    chk("pp_stall", {31'd0, ex_stall_o}, 32'd0);
    @(posedge clk); #1;
    chk("pp_idle",  {31'd0, idle_o},     32'd1);

    // Reset while a request is pending with two entries.
    tag_gnt_i = 1'b0;
    store(32'h0000_4000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    store(32'h0000_4004, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("prerst_req",   {31'd0, tag_req_o},  32'd1);
    chk("prerst_stall", {31'd0, ex_stall_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req",   {31'd0, tag_req_o},  32'd0);
    chk("midrst_idle",  {31'd0, idle_o},     32'd1);
    chk("midrst_stall", {31'd0, ex_stall_o}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tag_gnt_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_req",  {31'd0, tag_req_o}, 32'd0);
    chk("postrst_idle", {31'd0, idle_o},    32'd1);

`ifdef DIFT_STORE_CHECK_EN
    // Tainted-address store with check enabled: exception, no write.
    tcr_check_i = 1'b1;
    ex_valid_i = 1'b1; is_store_i = 1'b1; enable_a_i = 1'b1; addr_tag_i = 1'b1;
    store_addr_i = 32'h0000_5000; data_be_i = 4'hF;
    @(posedge clk); #1;
    ex_valid_i = 1'b0; is_store_i = 1'b0; enable_a_i = 1'b0; addr_tag_i = 1'b0;
    store_addr_i = '0; data_be_i = '0;
    chk("exc_pulse",    {31'd0, store_exc_o}, 32'd1);
    chk("exc_no_req",   {31'd0, tag_req_o},   32'd0);
    @(posedge clk); #1;
    chk("exc_one_cycle", {31'd0, store_exc_o}, 32'd0);
    chk("exc_still_idle", {31'd0, idle_o},    32'd1);
    tcr_check_i = 1'b0;
`endif

    // Drain any remaining expectations within a bounded window.
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #1;
    chk("drain_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
